// File: rtl/ssr_symfir.sv
// ssr_symfir: super-sample-rate symmetric FIR.
// Every clock carries NSAMPS consecutive samples (lane 0 oldest). Coefficients are
// double-buffered: writes go to a shadow bank, and coeff_update_i copies the shadow
// bank into the active bank used by the multiply stage.
// Pipeline: history -> preadd -> multiply -> adder tree ($clog2(NH) stages) -> scale/saturate.
// Optional build macro SSR_SYMFIR_ROUND_EN: round half up before the shift instead of
// truncating toward minus infinity. Latency is the same in both builds.
module ssr_symfir #(
    parameter int NSAMPS   = 4,
    parameter int NTAPS    = 15,
    parameter int INBITS   = 12,
    parameter int COEFBITS = 18,
    parameter int OUTBITS  = 12,
    parameter int SCALE    = 14
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic [NSAMPS*INBITS-1:0]              dat_i,
    input  logic                                  valid_i,
    output logic [NSAMPS*OUTBITS-1:0]             dat_o,
    output logic                                  valid_o,
    input  logic                                  coeff_wr_i,
    input  logic [$clog2((NTAPS+1)/2)-1:0]        coeff_addr_i,
    input  logic [COEFBITS-1:0]                   coeff_dat_i,
    input  logic                                  coeff_update_i,
    output logic [15:0]                           sat_cnt_o
);

    localparam int NH      = (NTAPS + 1) / 2;
    localparam int LOG2NH  = $clog2(NH);
    localparam int LATENCY = 4 + LOG2NH;
    localparam int HISTLEN = NTAPS - 1 + NSAMPS;
    localparam int BASE    = HISTLEN - NSAMPS;
    localparam int PREW    = INBITS + 1;
    localparam int PRODW   = PREW + COEFBITS;
    localparam int ACCW    = PRODW + LOG2NH;
    localparam int NLEAF   = 1 << LOG2NH;
    localparam int NHALF   = NLEAF / 2;

    // Saturation limits carried one bit wider than the accumulator so the rounding add cannot wrap.
    localparam logic signed [ACCW:0] MAXV = (ACCW+1)'((64'sd1 <<< (OUTBITS-1)) - 64'sd1);
    localparam logic signed [ACCW:0] MINV = ~MAXV;
`ifdef SSR_SYMFIR_ROUND_EN
    localparam int                   RNDSH = (SCALE > 0) ? SCALE - 1 : 0;
    localparam logic signed [ACCW:0] RND   = (SCALE > 0) ? ((ACCW+1)'(1) <<< RNDSH) : '0;
`else
    localparam logic signed [ACCW:0] RND   = '0;
`endif

    logic signed [INBITS-1:0]   r_hist   [0:HISTLEN-1];
    logic signed [COEFBITS-1:0] r_shadow [0:NH-1];
    logic signed [COEFBITS-1:0] r_active [0:NH-1];
    logic signed [PREW-1:0]     r_pre    [0:NSAMPS-1][0:NH-1];
    logic signed [PRODW-1:0]    r_prod   [0:NSAMPS-1][0:NH-1];
    logic signed [ACCW-1:0]     w_leaf   [0:NSAMPS-1][0:NLEAF-1];
    logic signed [ACCW-1:0]     r_lvl    [1:LOG2NH][0:NSAMPS-1][0:NHALF-1];
    logic signed [ACCW:0]       w_shf    [0:NSAMPS-1];
    logic signed [OUTBITS-1:0]  w_sat    [0:NSAMPS-1];
    logic [NSAMPS-1:0]          w_satf;
    logic [LATENCY-1:0]         r_vpipe;
    logic [NSAMPS*OUTBITS-1:0]  r_dat;
    logic [15:0]                r_satcnt;

    // Sample history: highest index is the newest sample; shifts by one beat only on valid_i.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < HISTLEN; i++) r_hist[i] <= '0;
        end else if (valid_i) begin
            for (int i = 0; i < BASE; i++) r_hist[i] <= r_hist[i+NSAMPS];
            for (int j = 0; j < NSAMPS; j++) r_hist[BASE+j] <= dat_i[j*INBITS +: INBITS];
        end
    end

    // Coefficient banks: the update copies the shadow as it was before any same-cycle write.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < NH; k++) begin
                r_shadow[k] <= '0;
                r_active[k] <= '0;
            end
        end else begin
            if (coeff_update_i) begin
                for (int k = 0; k < NH; k++) r_active[k] <= r_shadow[k];
            end
            if (coeff_wr_i && (int'(coeff_addr_i) < NH)) begin
                r_shadow[coeff_addr_i] <= coeff_dat_i;
            end
        end
    end

    // Valid tracking through the free-running data pipeline.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_vpipe <= '0;
        else          r_vpipe <= {r_vpipe[LATENCY-2:0], valid_i};
    end

    // Preadd of mirrored taps; the centre tap has no partner and is only sign-extended.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int j = 0; j < NSAMPS; j++)
                for (int k = 0; k < NH; k++) r_pre[j][k] <= '0;
        end else begin
            for (int j = 0; j < NSAMPS; j++) begin
                for (int k = 0; k < NH; k++) begin
                    if (k == NH - 1)
                        r_pre[j][k] <= PREW'(r_hist[BASE+j-k]);
                    else
                        r_pre[j][k] <= PREW'(r_hist[BASE+j-k]) + PREW'(r_hist[BASE+j-(NTAPS-1-k)]);
                end
            end
        end
    end

    // Multiply by the active bank; this is the only stage that reads the bank.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int j = 0; j < NSAMPS; j++)
                for (int k = 0; k < NH; k++) r_prod[j][k] <= '0;
        end else begin
            for (int j = 0; j < NSAMPS; j++)
                for (int k = 0; k < NH; k++)
                    r_prod[j][k] <= PRODW'(r_pre[j][k]) * PRODW'(r_active[k]);
        end
    end

    // Tree leaves: products sign-extended to full accumulator width, zero-padded to a power of two.
    always_comb begin
        for (int j = 0; j < NSAMPS; j++) begin
            for (int k = 0; k < NLEAF; k++) w_leaf[j][k] = '0;
            for (int k = 0; k < NH; k++)    w_leaf[j][k] = ACCW'(r_prod[j][k]);
        end
    end

    // Binary adder tree, one register level per halving; unused slots are held at zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int s = 1; s <= LOG2NH; s++)
                for (int j = 0; j < NSAMPS; j++)
                    for (int i = 0; i < NHALF; i++) r_lvl[s][j][i] <= '0;
        end else begin
            for (int j = 0; j < NSAMPS; j++) begin
                for (int i = 0; i < NHALF; i++)
                    r_lvl[1][j][i] <= w_leaf[j][2*i] + w_leaf[j][2*i+1];
                for (int s = 2; s <= LOG2NH; s++) begin
                    for (int i = 0; i < NHALF; i++) begin
                        if (i < (NLEAF >> s))
                            r_lvl[s][j][i] <= r_lvl[s-1][j][2*i] + r_lvl[s-1][j][2*i+1];
                        else
                            r_lvl[s][j][i] <= '0;
                    end
                end
            end
        end
    end

    // Scale (optionally rounded) and clamp each lane, flagging lanes that hit a limit.
    always_comb begin
        w_satf = '0;
        for (int j = 0; j < NSAMPS; j++) begin
            w_shf[j] = ((ACCW+1)'(r_lvl[LOG2NH][j][0]) + RND) >>> SCALE;
            w_sat[j] = w_shf[j][OUTBITS-1:0];
            if (w_shf[j] > MAXV) begin
                w_sat[j]  = MAXV[OUTBITS-1:0];
                w_satf[j] = 1'b1;
            end else if (w_shf[j] < MINV) begin
                w_sat[j]  = MINV[OUTBITS-1:0];
                w_satf[j] = 1'b1;
            end
        end
    end

    // Output register holds its last value between valid beats; saturation counter sticks at max.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_dat    <= '0;
            r_satcnt <= '0;
        end else if (r_vpipe[LATENCY-2]) begin
            for (int j = 0; j < NSAMPS; j++) r_dat[j*OUTBITS +: OUTBITS] <= w_sat[j];
            if ((|w_satf) && (r_satcnt != 16'hFFFF)) r_satcnt <= r_satcnt + 16'd1;
        end
    end

    assign dat_o     = r_dat;
    assign valid_o   = r_vpipe[LATENCY-1];
    assign sat_cnt_o = r_satcnt;

endmodule

// File: tb/tb_ssr_symfir.sv
// Testbench for ssr_symfir (NTAPS=5 build). Expected outputs come from a sample-stream
// convolution model with its own shadow/active coefficient banks.
module tb_ssr_symfir;

    localparam int NS    = 4;
    localparam int NTAPS = 5;
    localparam int INB   = 12;
    localparam int CB    = 18;
    localparam int OB    = 12;
    localparam int SC    = 14;
    localparam int NH    = 3;
    localparam int LAT   = 6;
    localparam int MAXC  = 4096;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NS*INB-1:0] dat_i = '0;
    logic              valid_i = 1'b0;
    logic [NS*OB-1:0]  dat_o;
    logic              valid_o;
    logic              coeff_wr = 1'b0;
    logic [1:0]        coeff_addr = '0;
    logic [CB-1:0]     coeff_dat = '0;
    logic              coeff_upd = 1'b0;
    logic [15:0]       sat_cnt;

    ssr_symfir #(
        .NSAMPS(NS), .NTAPS(NTAPS), .INBITS(INB), .COEFBITS(CB), .OUTBITS(OB), .SCALE(SC)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .dat_i          (dat_i),
        .valid_i        (valid_i),
        .dat_o          (dat_o),
        .valid_o        (valid_o),
        .coeff_wr_i     (coeff_wr),
        .coeff_addr_i   (coeff_addr),
        .coeff_dat_i    (coeff_dat),
        .coeff_update_i (coeff_upd),
        .sat_cnt_o      (sat_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int          xs     [0:MAXC*NS];
    bit          vin_h  [0:MAXC];
    int          beat_h [0:MAXC];
    int          act_h  [0:MAXC][0:NH-1];
    int          sh     [0:NH-1];
    int          ac     [0:NH-1];
    int          lane_v [0:NS-1];
    int          cyc, nbeats, exp_sat;
    logic [NS*OB-1:0] last_dat;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Unclamped y[n] for beat b lane j using the bank snapshot at index bk.
    function automatic longint ref_lane(input int b, input int j, input int bk);
        longint acc = 0;
        int     n   = b * NS + j;
        for (int t = 0; t < NTAPS; t++) begin
            int idx = (t < NH) ? t : NTAPS - 1 - t;
            if (n - t >= 0) acc += longint'(act_h[bk][idx]) * longint'(xs[n-t]);
        end
`ifdef SSR_SYMFIR_ROUND_EN
        acc += longint'(1) << (SC - 1);
`endif
        return acc >>> SC;
    endfunction

    task automatic clear_model();
        cyc = 0; nbeats = 0; exp_sat = 0; last_dat = '0;
        for (int k = 0; k < NH; k++) begin
            sh[k] = 0; ac[k] = 0; act_h[0][k] = 0;
        end
    endtask

    task automatic check_out();
        bit          ev;
        int          k, b;
        longint      e;
        bit          anysat;
        logic [NS*OB-1:0] pk;
        ev = (cyc >= LAT) ? vin_h[cyc-LAT] : 1'b0;
        chk("valid_o", longint'(valid_o), longint'(ev));
        if (ev) begin
            k = cyc - LAT;
            b = beat_h[k];
            anysat = 1'b0;
            pk = '0;
            for (int j = 0; j < NS; j++) begin
                e = ref_lane(b, j, k + 2);
                if (e > 2047)  begin e = 2047;  anysat = 1'b1; end
                if (e < -2048) begin e = -2048; anysat = 1'b1; end
                pk[j*OB +: OB] = e[OB-1:0];
                chk($sformatf("lane%0d_beat%0d", j, b), longint'($signed(dat_o[j*OB +: OB])), e);
            end
            if (anysat && exp_sat < 65535) exp_sat++;
            chk("sat_cnt", longint'(sat_cnt), longint'(exp_sat));
            last_dat = pk;
        end else begin
            chk("dat_hold", longint'(dat_o), longint'(last_dat));
        end
    endtask

    task automatic step(input bit v, input bit wr, input int addr, input int cd, input bit upd);
        @(negedge clk);
        valid_i    = v;
        coeff_wr   = wr;
        coeff_addr = addr[1:0];
        coeff_dat  = cd[CB-1:0];
        coeff_upd  = upd;
        for (int j = 0; j < NS; j++) dat_i[j*INB +: INB] = lane_v[j][INB-1:0];
        vin_h[cyc] = v;
        if (v) begin
            beat_h[cyc] = nbeats;
            for (int j = 0; j < NS; j++) xs[nbeats*NS+j] = lane_v[j];
            nbeats++;
        end
        @(posedge clk);
        cyc++;
        if (cyc >= MAXC - 1) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC - 1);
            $fatal(1, "cycle budget exceeded");
        end
        if (upd) for (int k = 0; k < NH; k++) ac[k] = sh[k];
        if (wr && addr < NH) sh[addr] = cd;
        for (int k = 0; k < NH; k++) act_h[cyc][k] = ac[k];
        #1 check_out();
    endtask

    task automatic set_lanes(input int a0, input int a1, input int a2, input int a3);
        lane_v[0] = a0; lane_v[1] = a1; lane_v[2] = a2; lane_v[3] = a3;
    endtask

    task automatic rand_lanes();
        for (int j = 0; j < NS; j++) lane_v[j] = int'($urandom_range(0, 4095)) - 2048;
    endtask

    function automatic int rand_coef(input int span);
        return int'($urandom_range(0, 2 * span)) - span;
    endfunction

    task automatic idle(input int n);
        set_lanes(0, 0, 0, 0);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic load(input int c0, input int c1, input int c2);
        set_lanes(0, 0, 0, 0);
        step(1'b0, 1'b1, 0, c0, 1'b0);
        step(1'b0, 1'b1, 1, c1, 1'b0);
        step(1'b0, 1'b1, 2, c2, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b1);
    endtask

    // Assert reset off the clock edge, check outputs clear at once, then release.
    task automatic do_reset(input int dly);
        #(dly);
        rst_n = 1'b0;
        #1;
        chk("rst_valid_o", longint'(valid_o), 0);
        chk("rst_dat_o", longint'(dat_o), 0);
        chk("rst_sat_cnt", longint'(sat_cnt), 0);
        valid_i = 1'b0; coeff_wr = 1'b0; coeff_upd = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        clear_model();
        set_lanes(0, 0, 0, 0);
        do_reset(2);

        // Single-tap impulse: passes 2047 straight through on lane 2.
        load(0, 0, 16384);
        idle(2);
        set_lanes(0, 0, 0, 0);    step(1'b1, 1'b0, 0, 0, 1'b0);
        set_lanes(0, 0, 2047, 0); step(1'b1, 1'b0, 0, 0, 1'b0);
        set_lanes(0, 0, 0, 0);
        for (int i = 0; i < LAT + 2; i++) step(1'b1, 1'b0, 0, 0, 1'b0);

        // Symmetric impulse response followed by random full-range data.
        do_reset(3);
        load(-18, 44, 16384);
        set_lanes(1000, 0, 0, 0); step(1'b1, 1'b0, 0, 0, 1'b0);
        set_lanes(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            rand_lanes();
            step(1'b1, 1'b0, 0, 0, 1'b0);
        end
        idle(LAT + 1);

        // Saturation, gapless then with valid_i toggling every clock.
        do_reset(4);
        load(0, 0, 32767);
        for (int g = 0; g < 2; g++) begin
            set_lanes(2047, 2047, 2047, 2047);
            for (int i = 0; i < 8 * (g + 1); i++) step((g == 0) || (i % 2 == 0), 1'b0, 0, 0, 1'b0);
            set_lanes(-2048, -2048, -2048, -2048);
            for (int i = 0; i < 8 * (g + 1); i++) step((g == 0) || (i % 2 == 0), 1'b0, 0, 0, 1'b0);
            idle(LAT + 1);
        end

        // Bank switching while streaming, with a write colliding with an update.
        do_reset(2);
        load(rand_coef(3000), rand_coef(3000), 8000 + rand_coef(6000));
        for (int i = 0; i < 60; i++) begin
            bit v, wr, upd;
            int a;
            rand_lanes();
            v   = ($urandom_range(0, 3) != 0);
            wr  = (i >= 5) && ($urandom_range(0, 2) == 0);
            a   = int'($urandom_range(0, 3));
            upd = (i == 20) || (i == 40) || (i == 52);
            if (upd && i != 52) begin
                wr = 1'b1;
                a  = 2;
            end
            step(v, wr, a, (a == 2) ? 8000 + rand_coef(6000) : rand_coef(3000), upd);
        end
        idle(LAT + 1);

        // Asynchronous reset in the middle of a stream, then a fresh zero-history start.
        load(rand_coef(2000), rand_coef(2000), 12000);
        for (int i = 0; i < 10; i++) begin
            rand_lanes();
            step(1'b1, 1'b0, 0, 0, 1'b0);
        end
        do_reset(2);
        load(rand_coef(2000), rand_coef(2000), 12000);
        for (int i = 0; i < 20; i++) begin
            rand_lanes();
            step($urandom_range(0, 4) != 0, 1'b0, 0, 0, 1'b0);
        end
        idle(LAT + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
